// File: rtl/mem_arb_if.sv
// mem_arb_if: requester-side and controller-side signals of the memory arbiter.
interface mem_arb_if #(
    parameter int NPORT = 3
);
    logic [NPORT-1:0]    preq;
    logic [20*NPORT-1:0] paddr;
    logic [NPORT-1:0]    pwr;
    logic [32*NPORT-1:0] pwdata;
    logic [NPORT-1:0]    pack;
    logic [31:0]         prdata;
    logic [NPORT-1:0]    povf;
    logic                memreset;
    logic                memreq;
    logic [19:0]         memaddr;
    logic                memwr;
    logic [31:0]         memwdata;
    logic                memack;
    logic [31:0]         memrdata;

    modport slave (
        input  preq, paddr, pwr, pwdata, memreset, memack, memrdata,
        output pack, prdata, povf, memreq, memaddr, memwr, memwdata
    );

    modport master (
        output preq, paddr, pwr, pwdata, memreset, memack, memrdata,
        input  pack, prdata, povf, memreq, memaddr, memwr, memwdata
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one single-transaction memory controller port.
// Requests are held per port and issued one at a time; ack/read data route back to the owner.
module mem_arb #(
    parameter int NPORT = 3,
    parameter int DRAIN = 64
) (
    input logic        clk,
    input logic        rst,
    mem_arb_if.slave   bus
);
    localparam int W  = NPORT > 1 ? $clog2(NPORT) : 1;
    localparam int CW = DRAIN > 1 ? $clog2(DRAIN) : 1;

    typedef enum logic [1:0] {S_DRAIN, S_IDLE, S_WAIT} state_t;

    state_t           state, nstate;
    logic [CW-1:0]    cnt;
    logic [NPORT-1:0] pending, clr, eff, cap;
    logic [W-1:0]     ptr, grant, win, idx;
    logic             any, gnt, done;
    logic [19:0]      hold_addr  [NPORT];
    logic             hold_wr    [NPORT];
    logic [31:0]      hold_wdata [NPORT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_DRAIN;
        else     state <= nstate;
    end

    // A stray ack during DRAIN means the controller has finished whatever was in flight.
    always_comb begin
        nstate = state;
        case (state)
            S_DRAIN: nstate = (bus.memack || cnt == '0) ? S_IDLE : S_DRAIN;
            S_IDLE:  nstate = (!bus.memreset && any) ? S_WAIT : S_IDLE;
            S_WAIT:  nstate = bus.memack ? S_IDLE : S_WAIT;
            default: nstate = S_DRAIN;
        endcase
    end

    always_comb begin
        any  = |pending;
        gnt  = state == S_IDLE && !bus.memreset && any;
        done = state == S_WAIT && bus.memack;
        clr  = done ? NPORT'(1) << grant : '0;
        eff  = pending & ~clr;
        cap  = bus.preq & ~eff;
        win  = '0;
        idx  = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % NPORT);
            if (pending[idx]) win = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= CW'(DRAIN - 1);
            pending      <= '0;
            ptr          <= '0;
            grant        <= '0;
            bus.pack     <= '0;
            bus.povf     <= '0;
            bus.memreq   <= 1'b0;
            bus.memaddr  <= '0;
            bus.memwr    <= 1'b0;
            bus.memwdata <= '0;
            bus.prdata   <= '0;
            for (int i = 0; i < NPORT; i++) begin
                hold_addr[i]  <= '0;
                hold_wr[i]    <= 1'b0;
                hold_wdata[i] <= '0;
            end
        end else begin
            cnt      <= (state == S_DRAIN && cnt != '0) ? cnt - 1'b1 : cnt;
            pending  <= eff | bus.preq;
            bus.povf <= bus.povf | (bus.preq & eff);
            bus.pack <= clr;
            bus.memreq <= gnt;
            for (int i = 0; i < NPORT; i++) begin
                if (cap[i]) begin
                    hold_addr[i]  <= bus.paddr[20*i +: 20];
                    hold_wr[i]    <= bus.pwr[i];
                    hold_wdata[i] <= bus.pwdata[32*i +: 32];
                end
            end
            if (gnt) begin
                bus.memaddr  <= hold_addr[win];
                bus.memwr    <= hold_wr[win];
                bus.memwdata <= hold_wdata[win];
                grant        <= win;
                ptr          <= (win == W'(NPORT - 1)) ? '0 : win + 1'b1;
            end
            if (done && !bus.memwr) bus.prdata <= bus.memrdata;
        end
    end
endmodule
